iobs_post: RTL and testbench
============================

IOBS_POST -- requirements
Module: iobs_post

Interface
REQ-001 Parameter POSTEN, default 1: 1 = writes are posted into a 2-entry buffer; 0 = writes are acknowledged only after I/O completion.
REQ-002 Port C16M, input, 1: sole clock; all state updates on its rising edge.
REQ-003 Port RES, input, 1: reset, asynchronous and active-high; clears all state immediately.
REQ-004 Port CPUREQ, input, 1: CPU-side I/O request, level.
REQ-005 Port CPURW, input, 1: 1 = read, 0 = write.
REQ-006 Ports CPULDS and CPUUDS, input, 1 each: lower and upper byte strobes, active-high.
REQ-007 Port CPUA, input, 23 (A[23:1]): request address.
REQ-008 Port CPUD, input, 16: write data.
REQ-009 Port CPUACK, output, 1: one-cycle acknowledge pulse.
REQ-010 Port CPUQ, output, 16: read data, valid from the CPUACK cycle until the next read completes.
REQ-011 Ports IOREQ, IORW, IOLDS and IOUDS, output, 1 each: request to the downstream I/O bus master.
REQ-012 Port IOA, output, 23: address to the bus master.
REQ-013 Port IOD, output, 16: write data to the bus master.
REQ-014 Port IOACT, input, 1: bus master cycle active.
REQ-015 Port IODONE, input, 1: bus master termination, level.
REQ-016 Port IODIN, input, 16: latched bus read data.
REQ-017 Port BUSY, output, 1: buffer non-empty or engine not IDLE.

Function
REQ-018 Acceptance is edge-qualified: once CPUACK has pulsed, CPUREQ SHALL be ignored until it has been sampled low at least once (the ARMED flag).
REQ-019 Write, POSTEN=1: when CPUREQ, ARMED and buffer count<2 are sampled at edge N, the entry {A,D,LDS,UDS} SHALL be pushed at N and CPUACK SHALL be high for the cycle N..N+1 only.
REQ-020 Full rule: count==2 at edge N SHALL block a push at N even if a pop occurs at N; the push is taken at N+1.
REQ-021 Read: a read SHALL be accepted only when count==0, the engine is IDLE and no push occurs in the same cycle; it then loads the engine directly with no buffer entry.
REQ-022 Write, POSTEN=0: a write SHALL be treated like a read for acceptance and acknowledge timing, except that CPUQ is unchanged.
REQ-023 Engine states: IDLE, REQ, ACT, DONE; reset state IDLE.
REQ-024 IDLE: if the buffer is non-empty or a read/unposted request has been accepted, the engine SHALL load the head (or request) into the IO* registers and go to REQ; IOREQ SHALL be 1 from the next cycle.
REQ-025 REQ: IOREQ held at 1; on IOACT=1, go to ACT and set IOREQ to 0.
REQ-026 ACT: on IODONE=1, go to DONE. For a read, IODIN SHALL be captured into CPUQ; for a posted write, the buffer SHALL be popped at that edge.
REQ-027 DONE: on IOACT=0, return to IDLE. For a read or unposted write, CPUACK SHALL pulse for the single cycle after the DONE->IDLE transition.
REQ-028 IORW, IOLDS, IOUDS, IOA and IOD SHALL remain stable from the IOREQ rise until the engine re-enters IDLE.
REQ-029 Ordering: the buffer SHALL be FIFO, and a read SHALL never overtake a buffered write.
REQ-030 A push and a pop on the same edge SHALL leave count unchanged; count SHALL never exceed 2 nor go below 0.
REQ-031 Pointers SHALL be 1 bit each and wrap modulo 2.
REQ-032 IODONE outside ACT and IOACT outside REQ/ACT/DONE SHALL be ignored.

Reset
REQ-033 While RES=1 and after its release, the block SHALL be in this state:
- IOREQ, IORW, IOLDS, IOUDS, CPUACK and BUSY = 0;
- IOA, IOD and CPUQ = 0;
- count = 0, pointers = 0, engine = IDLE, ARMED = 1.
REQ-034 A reset mid-cycle SHALL discard buffered writes and the in-flight request without generating CPUACK.

Verification
REQ-035 Posted write: write A=0x7FFFF8, D=0x1234, LDS=UDS=1 at edge N -> CPUACK at N+1 only; IOREQ=1 from N+2; IOA=0x7FFFF8, IOD=0x1234, IORW=0; IOACT then IODONE -> BUSY falls after IOACT falls.
REQ-036 Full buffer: three back-to-back writes (CPUREQ toggled between them) while IOACT is held low -> first two acknowledged; third ack withheld until the first IODONE pop, then issued; the three IO cycles occur in issue order.
REQ-037 Read behind writes: two writes then a read with IODIN=0xBEEF -> read IOREQ only after the second write's DONE->IDLE; CPUQ=0xBEEF; CPUACK in the cycle after IOACT falls.
REQ-038 Held CPUREQ: CPUREQ held high across CPUACK -> no second acceptance until CPUREQ is sampled low.
REQ-039 POSTEN=0 write -> CPUACK only after IODONE and IOACT fall; CPUQ unchanged.
REQ-040 Reset mid-ACT with one write buffered -> all outputs 0 at once; no IOREQ or CPUACK after release until a new request arrives.

Source files
------------

// File: rtl/iobs_post.sv
// iobs_post: CPU-to-I/O bridge with a 2-entry posted-write FIFO and a four-state bus-master request engine.
module iobs_post #(
  parameter bit POSTEN = 1'b1
) (
  input  logic        C16M,
  input  logic        RES,
  input  logic        CPUREQ,
  input  logic        CPURW,
  input  logic        CPULDS,
  input  logic        CPUUDS,
  input  logic [22:0] CPUA,
  input  logic [15:0] CPUD,
  output logic        CPUACK,
  output logic [15:0] CPUQ,
  output logic        IOREQ,
  output logic        IORW,
  output logic        IOLDS,
  output logic        IOUDS,
  output logic [22:0] IOA,
  output logic [15:0] IOD,
  input  logic        IOACT,
  input  logic        IODONE,
  input  logic [15:0] IODIN,
  output logic        BUSY
);
  typedef enum logic [1:0] {IDLE, REQ, ACT, DONE} state_t;
  state_t state, state_n;
  logic [40:0] fifo [2];
  logic        wptr, rptr;
  logic [1:0]  count;
  logic        armed, cur_dir, cur_rd;
  logic        take, push, direct, pop, load, done_exit;
  always_comb begin
    take      = CPUREQ & armed;
    push      = take & POSTEN & ~CPURW & (count != 2'd2);
    direct    = take & (CPURW | ~POSTEN) & (count == 2'd0) & (state == IDLE);
    pop       = (state == ACT) & IODONE & ~cur_dir;
    load      = (state == IDLE) & (direct | (count != 2'd0));
    done_exit = (state == DONE) & ~IOACT;
    BUSY      = (count != 2'd0) | (state != IDLE);
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = load ? REQ : IDLE;
      REQ:  state_n = IOACT ? ACT : REQ;
      ACT:  state_n = IODONE ? DONE : ACT;
      DONE: state_n = IOACT ? DONE : IDLE;
    endcase
  end
  always_ff @(posedge C16M or posedge RES)
    if (RES) state <= IDLE;
    else     state <= state_n;
  // A direct (read or unposted) request bypasses the FIFO; it is only taken when the FIFO is empty.
  always_ff @(posedge C16M or posedge RES) begin
    if (RES) begin
      fifo[0] <= '0;
      fifo[1] <= '0;
      wptr    <= 1'b0;
      rptr    <= 1'b0;
      count   <= 2'd0;
      armed   <= 1'b1;
      cur_dir <= 1'b0;
      cur_rd  <= 1'b0;
      CPUACK  <= 1'b0;
      CPUQ    <= '0;
      IOREQ   <= 1'b0;
      IORW    <= 1'b0;
      IOLDS   <= 1'b0;
      IOUDS   <= 1'b0;
      IOA     <= '0;
      IOD     <= '0;
    end else begin
      if (push) fifo[wptr] <= {CPUA, CPUD, CPULDS, CPUUDS};
      wptr   <= wptr ^ push;
      rptr   <= rptr ^ pop;
      count  <= count + {1'b0, push} - {1'b0, pop};
      armed  <= (push | direct) ? 1'b0 : (~CPUREQ | armed);
      CPUACK <= push | (done_exit & cur_dir);
      if (load) begin
        IOREQ                   <= 1'b1;
        IORW                    <= direct & CPURW;
        {IOA, IOD, IOLDS, IOUDS} <= direct ? {CPUA, CPUD, CPULDS, CPUUDS} : fifo[rptr];
        cur_dir                 <= direct;
        cur_rd                  <= direct & CPURW;
      end
      if (state == REQ && IOACT) IOREQ <= 1'b0;
      if (state == ACT && IODONE && cur_rd) CPUQ <= IODIN;
    end
  end
endmodule

// File: tb/tb_iobs_post.sv
// tb_iobs_post: directed scoreboard bench for posted and unposted configurations of iobs_post.
module tb_iobs_post;
  logic        C16M = 1'b0;
  logic        RES = 1'b1;
  logic        CPUREQ = 1'b0, creq_np = 1'b0, CPURW = 1'b0, CPULDS = 1'b0, CPUUDS = 1'b0;
  logic [22:0] CPUA = '0;
  logic [15:0] CPUD = '0;
  logic        IOACT = 1'b0, IODONE = 1'b0;
  logic [15:0] IODIN = '0;
  logic        p_ack, p_ioreq, p_iorw, p_iolds, p_iouds, p_busy;
  logic [15:0] p_cpuq, p_iod;
  logic [22:0] p_ioa;
  logic        n_ack, n_ioreq, n_iorw, n_iolds, n_iouds, n_busy;
  logic [15:0] n_cpuq, n_iod;
  logic [22:0] n_ioa;
  logic        sel = 1'b0;
  logic        v_ack, v_ioreq, v_iorw, v_iolds, v_iouds, v_busy;
  logic [22:0] v_ioa;
  logic [15:0] v_iod;
  logic        ack_at_done;
  int          n_assert = 0, n_fail = 0;
  typedef struct packed {logic rw; logic [22:0] a; logic [15:0] d; logic lds; logic uds;} exp_t;
  exp_t exp_q[$];

  always #5 C16M = ~C16M;

  iobs_post #(.POSTEN(1'b1)) u_post (
    .C16M(C16M), .RES(RES), .CPUREQ(CPUREQ), .CPURW(CPURW), .CPULDS(CPULDS), .CPUUDS(CPUUDS),
    .CPUA(CPUA), .CPUD(CPUD), .CPUACK(p_ack), .CPUQ(p_cpuq), .IOREQ(p_ioreq), .IORW(p_iorw),
    .IOLDS(p_iolds), .IOUDS(p_iouds), .IOA(p_ioa), .IOD(p_iod), .IOACT(IOACT), .IODONE(IODONE),
    .IODIN(IODIN), .BUSY(p_busy));

  iobs_post #(.POSTEN(1'b0)) u_np (
    .C16M(C16M), .RES(RES), .CPUREQ(creq_np), .CPURW(CPURW), .CPULDS(CPULDS), .CPUUDS(CPUUDS),
    .CPUA(CPUA), .CPUD(CPUD), .CPUACK(n_ack), .CPUQ(n_cpuq), .IOREQ(n_ioreq), .IORW(n_iorw),
    .IOLDS(n_iolds), .IOUDS(n_iouds), .IOA(n_ioa), .IOD(n_iod), .IOACT(IOACT), .IODONE(IODONE),
    .IODIN(IODIN), .BUSY(n_busy));

  assign v_ack   = sel ? n_ack : p_ack;
  assign v_ioreq = sel ? n_ioreq : p_ioreq;
  assign v_iorw  = sel ? n_iorw : p_iorw;
  assign v_iolds = sel ? n_iolds : p_iolds;
  assign v_iouds = sel ? n_iouds : p_iouds;
  assign v_busy  = sel ? n_busy : p_busy;
  assign v_ioa   = sel ? n_ioa : p_ioa;
  assign v_iod   = sel ? n_iod : p_iod;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ioreq"}, 64'(p_ioreq), 64'd0);
    check({tag, "_iorw"}, 64'(p_iorw), 64'd0);
    check({tag, "_iolds"}, 64'(p_iolds), 64'd0);
    check({tag, "_iouds"}, 64'(p_iouds), 64'd0);
    check({tag, "_ack"}, 64'(p_ack), 64'd0);
    check({tag, "_busy"}, 64'(p_busy), 64'd0);
    check({tag, "_ioa"}, 64'(p_ioa), 64'd0);
    check({tag, "_iod"}, 64'(p_iod), 64'd0);
    check({tag, "_cpuq"}, 64'(p_cpuq), 64'd0);
  endtask

  // Bus-master model: waits for IOREQ, checks the request against the scoreboard head, then runs ACT/DONE.
  task automatic serve(input logic [15:0] rdata);
    exp_t e;
    int   n;
    n = 0;
    while (v_ioreq !== 1'b1 && n < 40) begin
      @(negedge C16M);
      n++;
    end
    check("ioreq_rise", 64'(v_ioreq), 64'd1);
    check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
    if (v_ioreq !== 1'b1 || exp_q.size() == 0) return;
    e = exp_q.pop_front();
    check("iorw", 64'(v_iorw), 64'(e.rw));
    check("ioa", 64'(v_ioa), 64'(e.a));
    check("iolds", 64'(v_iolds), 64'(e.lds));
    check("iouds", 64'(v_iouds), 64'(e.uds));
    if (!e.rw) check("iod", 64'(v_iod), 64'(e.d));
    IODIN = rdata;
    IOACT = 1'b1;
    @(negedge C16M);
    check("ioreq_drop", 64'(v_ioreq), 64'd0);
    check("ioa_stable", 64'(v_ioa), 64'(e.a));
    IODONE = 1'b1;
    @(negedge C16M);
    ack_at_done = v_ack;
    check("busy_in_done", 64'(v_busy), 64'd1);
    check("iorw_stable", 64'(v_iorw), 64'(e.rw));
    IODONE = 1'b0;
    IOACT  = 1'b0;
    @(negedge C16M);
  endtask

  task automatic cpu_write(input logic [22:0] a, input logic [15:0] d, input logic lds, input logic uds);
    CPUREQ = 1'b1; CPURW = 1'b0; CPUA = a; CPUD = d; CPULDS = lds; CPUUDS = uds;
    exp_q.push_back({1'b0, a, d, lds, uds});
    @(negedge C16M);
    check("wr_ack", 64'(p_ack), 64'd1);
    CPUREQ = 1'b0;
    @(negedge C16M);
    check("wr_ack_one_cycle", 64'(p_ack), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    @(negedge C16M);
    @(negedge C16M);
    check_idle_outputs("reset_hold");
    check("np_reset_ioreq", 64'(n_ioreq), 64'd0);
    check("np_reset_cpuq", 64'(n_cpuq), 64'd0);
    RES = 1'b0;
    @(negedge C16M);
    check_idle_outputs("reset_release");
    // Posted write at the top of the address range
    CPUREQ = 1'b1; CPURW = 1'b0; CPUA = 23'h7FFFF8; CPUD = 16'h1234; CPULDS = 1'b1; CPUUDS = 1'b1;
    exp_q.push_back({1'b0, 23'h7FFFF8, 16'h1234, 1'b1, 1'b1});
    @(negedge C16M);
    check("pw_ack", 64'(p_ack), 64'd1);
    check("pw_ioreq_early", 64'(p_ioreq), 64'd0);
    check("pw_busy", 64'(p_busy), 64'd1);
    CPUREQ = 1'b0;
    @(negedge C16M);
    check("pw_ack_drop", 64'(p_ack), 64'd0);
    check("pw_ioreq", 64'(p_ioreq), 64'd1);
    serve(16'h0000);
    check("pw_busy_end", 64'(p_busy), 64'd0);
    check("pw_no_ack", 64'(p_ack), 64'd0);
    // Full buffer: third write held off until the first pop
    cpu_write(23'h000100, 16'hA001, 1'b1, 1'b0);
    cpu_write(23'h000102, 16'hA002, 1'b0, 1'b1);
    CPUREQ = 1'b1; CPURW = 1'b0; CPUA = 23'h000104; CPUD = 16'hA003; CPULDS = 1'b1; CPUUDS = 1'b1;
    exp_q.push_back({1'b0, 23'h000104, 16'hA003, 1'b1, 1'b1});
    @(negedge C16M);
    check("full_block_0", 64'(p_ack), 64'd0);
    @(negedge C16M);
    check("full_block_1", 64'(p_ack), 64'd0);
    serve(16'h0000);
    check("full_no_ack_at_pop", 64'(ack_at_done), 64'd0);
    check("full_ack_after_pop", 64'(p_ack), 64'd1);
    CPUREQ = 1'b0;
    serve(16'h0000);
    serve(16'h0000);
    check("full_drained", 64'(p_busy), 64'd0);
    // Read queued behind two posted writes
    cpu_write(23'h000200, 16'hB001, 1'b1, 1'b1);
    cpu_write(23'h000202, 16'hB002, 1'b1, 1'b1);
    CPUREQ = 1'b1; CPURW = 1'b1; CPUA = 23'h000123; CPUD = 16'h0000; CPULDS = 1'b1; CPUUDS = 1'b1;
    exp_q.push_back({1'b1, 23'h000123, 16'h0000, 1'b1, 1'b1});
    serve(16'h0000);
    check("rd_no_ack_w1", 64'(p_ack), 64'd0);
    serve(16'h0000);
    check("rd_not_overtake", 64'(p_ioreq), 64'd0);
    check("rd_no_ack_w2", 64'(p_ack), 64'd0);
    serve(16'hBEEF);
    check("rd_ack_at_done", 64'(ack_at_done), 64'd0);
    check("rd_ack", 64'(p_ack), 64'd1);
    check("rd_cpuq", 64'(p_cpuq), 64'hBEEF);
    CPUREQ = 1'b0; CPURW = 1'b0;
    @(negedge C16M);
    check("rd_ack_one_cycle", 64'(p_ack), 64'd0);
    check("rd_cpuq_hold", 64'(p_cpuq), 64'hBEEF);
    // Held CPUREQ: only one acceptance
    CPUREQ = 1'b1; CPURW = 1'b0; CPUA = 23'h055555; CPUD = 16'h5A5A; CPULDS = 1'b0; CPUUDS = 1'b1;
    exp_q.push_back({1'b0, 23'h055555, 16'h5A5A, 1'b0, 1'b1});
    @(negedge C16M);
    check("held_ack", 64'(p_ack), 64'd1);
    @(negedge C16M);
    check("held_no_reack_0", 64'(p_ack), 64'd0);
    @(negedge C16M);
    check("held_no_reack_1", 64'(p_ack), 64'd0);
    serve(16'h0000);
    check("held_no_reack_2", 64'(p_ack), 64'd0);
    check("held_no_second_push", 64'(p_busy), 64'd0);
    CPUREQ = 1'b0;
    @(negedge C16M);
    check("held_idle", 64'(p_busy), 64'd0);
    // Unposted write on the POSTEN=0 instance
    sel = 1'b1;
    creq_np = 1'b1; CPURW = 1'b0; CPUA = 23'h012345; CPUD = 16'hC0DE; CPULDS = 1'b1; CPUUDS = 1'b1;
    exp_q.push_back({1'b0, 23'h012345, 16'hC0DE, 1'b1, 1'b1});
    @(negedge C16M);
    check("np_no_early_ack", 64'(n_ack), 64'd0);
    check("np_ioreq", 64'(n_ioreq), 64'd1);
    check("np_post_idle", 64'(p_busy), 64'd0);
    serve(16'h5555);
    check("np_no_ack_at_done", 64'(ack_at_done), 64'd0);
    check("np_ack", 64'(n_ack), 64'd1);
    check("np_cpuq_unchanged", 64'(n_cpuq), 64'd0);
    creq_np = 1'b0;
    @(negedge C16M);
    check("np_ack_one_cycle", 64'(n_ack), 64'd0);
    sel = 1'b0;
    // Stray IOACT/IODONE while idle
    IOACT = 1'b1; IODONE = 1'b1;
    @(negedge C16M);
    check("stray_busy", 64'(p_busy), 64'd0);
    check("stray_ioreq", 64'(p_ioreq), 64'd0);
    IOACT = 1'b0; IODONE = 1'b0;
    @(negedge C16M);
    // Asynchronous reset while a write is in ACT and another is buffered
    cpu_write(23'h000300, 16'hD001, 1'b1, 1'b1);
    cpu_write(23'h000302, 16'hD002, 1'b1, 1'b1);
    IOACT = 1'b1;
    @(negedge C16M);
    check("rst_in_act", 64'(p_ioreq), 64'd0);
    check("rst_ioa_loaded", 64'(p_ioa), 64'h000300);
    #2 RES = 1'b1;
    #1 check_idle_outputs("rst_async");
    @(negedge C16M);
    IOACT = 1'b0;
    RES   = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      @(negedge C16M);
      check("post_rst_ioreq", 64'(p_ioreq), 64'd0);
      check("post_rst_ack", 64'(p_ack), 64'd0);
      check("post_rst_busy", 64'(p_busy), 64'd0);
    end
    cpu_write(23'h000400, 16'hE001, 1'b1, 1'b0);
    serve(16'h0000);
    check("post_rst_drained", 64'(p_busy), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
